// File: rtl/progmem_loader.sv
// progmem_loader: framed UART byte stream -> little-endian 32-bit word writes on progmem port B.
// Define PROGMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte on every frame.
module progmem_loader #(
   parameter int         AWIDTH    = 14,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [31:0]       mem_din,
   output logic              mem_we,
   output logic [3:0]        mem_en,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [3:0] {
      IDLE, ADDR0, ADDR1, LEN0, LEN1, DATA, WRITE,
`ifdef PROGMEM_LOADER_CHECKSUM_EN
      CHK,
`endif
      FIN
   } state_t;

`ifdef PROGMEM_LOADER_CHECKSUM_EN
   localparam state_t AFTER_DATA = CHK;
`else
   localparam state_t AFTER_DATA = FIN;
`endif

   state_t            state_reg;
   logic [AWIDTH-1:0] addr_reg;
   logic [15:0]       count_reg;
   logic [7:0]        lo_reg;
   logic [31:0]       word_reg;
   logic [1:0]        byte_cnt_reg;
   logic              rx_ready_reg;
   logic              mem_we_reg;
   logic              busy_reg;
   logic              done_reg;
   logic [AWIDTH-1:0] mem_addr_reg;
   logic [31:0]       mem_din_reg;
   logic              accept;
   logic [15:0]       field;
   logic [31:0]       word_full;

   assign accept    = rx_valid && rx_ready_reg;
   assign field     = {rx_data, lo_reg};
   assign word_full = {rx_data, word_reg[31:8]};

   assign rx_ready = rx_ready_reg;
   assign mem_addr = mem_addr_reg;
   assign mem_din  = mem_din_reg;
   assign mem_we   = mem_we_reg;
   assign busy     = busy_reg;
   assign done     = done_reg;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_en
         assign mem_en[gi] = mem_we_reg;
      end
   endgenerate

`ifdef PROGMEM_LOADER_CHECKSUM_EN
   logic [7:0] xor_reg;
   logic       err_reg;
   assign err = err_reg;
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg    <= IDLE;
         addr_reg     <= '0;
         count_reg    <= '0;
         lo_reg       <= '0;
         word_reg     <= '0;
         byte_cnt_reg <= '0;
         rx_ready_reg <= 1'b1;
         mem_we_reg   <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         mem_addr_reg <= '0;
         mem_din_reg  <= '0;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
         xor_reg      <= '0;
         err_reg      <= 1'b0;
`endif
      end else begin
         // Strobes are single-cycle; branches below override these defaults.
         mem_we_reg   <= 1'b0;
         done_reg     <= 1'b0;
         rx_ready_reg <= 1'b1;
         case (state_reg)
            IDLE: if (accept && rx_data == SYNC_BYTE) begin
               state_reg <= ADDR0;
               busy_reg  <= 1'b1;
            end
            ADDR0: if (accept) begin
               lo_reg    <= rx_data;
               state_reg <= ADDR1;
            end
            ADDR1: if (accept) begin
               addr_reg  <= field[AWIDTH-1:0];
               state_reg <= LEN0;
            end
            LEN0: if (accept) begin
               lo_reg    <= rx_data;
               state_reg <= LEN1;
            end
            LEN1: if (accept) begin
               count_reg    <= field;
               byte_cnt_reg <= 2'd0;
               if (field == 16'd0) begin
                  state_reg    <= AFTER_DATA;
                  done_reg     <= (AFTER_DATA == FIN);
                  rx_ready_reg <= (AFTER_DATA != FIN);
               end else begin
                  state_reg <= DATA;
               end
            end
            DATA: if (accept) begin
               word_reg     <= word_full;
               byte_cnt_reg <= byte_cnt_reg + 2'd1;
               if (byte_cnt_reg == 2'd3) begin
                  state_reg    <= WRITE;
                  mem_we_reg   <= 1'b1;
                  rx_ready_reg <= 1'b0;
                  mem_addr_reg <= addr_reg;
                  mem_din_reg  <= word_full;
               end
            end
            WRITE: begin
               addr_reg  <= addr_reg + 1'b1;
               count_reg <= count_reg - 16'd1;
               if (count_reg != 16'd1) begin
                  state_reg <= DATA;
               end else begin
                  state_reg    <= AFTER_DATA;
                  done_reg     <= (AFTER_DATA == FIN);
                  rx_ready_reg <= (AFTER_DATA != FIN);
               end
            end
`ifdef PROGMEM_LOADER_CHECKSUM_EN
            CHK: if (accept) begin
               if (rx_data == xor_reg) begin
                  state_reg    <= FIN;
                  done_reg     <= 1'b1;
                  rx_ready_reg <= 1'b0;
               end else begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
                  err_reg   <= 1'b1;
               end
            end
`endif
            FIN: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
`ifdef PROGMEM_LOADER_CHECKSUM_EN
         if (state_reg == IDLE && accept && rx_data == SYNC_BYTE) begin
            xor_reg <= 8'h00;
            err_reg <= 1'b0;
         end else if (accept && state_reg inside {ADDR0, ADDR1, LEN0, LEN1, DATA}) begin
            xor_reg <= xor_reg ^ rx_data;
         end
`endif
      end
   end

endmodule

// File: tb/tb_progmem_loader.sv
// Directed testbench for progmem_loader; expected writes are queued at stimulus time and checked on mem_we.
module tb_progmem_loader;

   logic        clk = 1'b0;
   logic        rstn;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [13:0] mem_addr;
   logic [31:0] mem_din;
   logic        mem_we;
   logic [3:0]  mem_en;
   logic        busy;
   logic        done;
   logic        err;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   int wr_cnt = 0;
   logic [45:0] exp_q[$];
   logic [31:0] wbuf[0:7];
   logic [7:0]  chk_acc;

   progmem_loader #(.AWIDTH(14), .SYNC_BYTE(8'hA5)) dut (
      .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_en(mem_en),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, expv);
      end
   endtask

   // Write scoreboard and strobe invariants, sampled mid-cycle.
   always @(negedge clk) begin
      logic [45:0] e;
      if (rstn === 1'b1) begin
         check("ready_low_only_in_write_fin", rx_ready, !(mem_we || done));
         check("mem_en", mem_en, mem_we ? 4'hF : 4'h0);
         if (mem_we) begin
            wr_cnt++;
            check("write_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("wr_addr", mem_addr, e[45:32]);
               check("wr_data", mem_din, e[31:0]);
            end
         end
         if (done) begin
            done_cnt++;
            check("done_after_writes", exp_q.size(), 0);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (n >= 10) check("rx_ready_timeout", 0, 1);
      @(negedge clk);
   endtask

   task automatic send_sum(input logic [7:0] b);
      chk_acc = chk_acc ^ b;
      send_byte(b);
   endtask

   task automatic wait_done(input int d0, input bit expect_done);
      for (int i = 0; i < 8; i++) begin
         if (done_cnt != d0) break;
         @(negedge clk);
         #1;
      end
      check("done_count", done_cnt, expect_done ? d0 + 1 : d0);
   endtask

   task automatic frame(input logic [15:0] a, input int len, input bit bad_chk);
      logic [13:0] ea;
      logic [31:0] w;
      int d0;
      ea = a[13:0];
      d0 = done_cnt;
      chk_acc = 8'h00;
      send_byte(8'hA5);
      send_sum(a[7:0]);
      send_sum(a[15:8]);
      send_sum(len[7:0]);
      send_sum(len[15:8]);
      for (int i = 0; i < len; i++) begin
         w = wbuf[i];
         exp_q.push_back({ea, w});
         ea = ea + 14'd1;
         for (int j = 0; j < 4; j++) send_sum(w[8*j +: 8]);
      end
`ifdef PROGMEM_LOADER_CHECKSUM_EN
      send_byte(bad_chk ? (chk_acc ^ 8'h5A) : chk_acc);
`endif
      rx_valid = 1'b0;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
      wait_done(d0, !bad_chk);
      if (bad_chk) check("err_after_bad_chk", err, 1);
`else
      wait_done(d0, 1'b1);
`endif
      @(negedge clk);
      check("busy_idle_after_frame", busy, 0);
      check("queue_drained", exp_q.size(), 0);
   endtask

   initial begin
      int w0;
      int d0;
      rstn = 1'b0;
      rx_valid = 1'b0;
      rx_data = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_rx_ready", rx_ready, 1);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_din", mem_din, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      rstn = 1'b1;
      @(negedge clk);

      // Two-word frame at 0x0010.
      wbuf[0] = 32'h12345678;
      wbuf[1] = 32'hDEADBEEF;
      frame(16'h0010, 2, 1'b0);
      check("hold_mem_addr", mem_addr, 14'h0011);
      check("hold_mem_din", mem_din, 32'hDEADBEEF);
      check("wr_cnt_t1", wr_cnt, 2);

      // Junk before sync is dropped; 0xA5 inside the frame is data.
      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'h3C);
      rx_valid = 1'b0;
      @(negedge clk);
      check("junk_not_busy", busy, 0);
      wbuf[0] = 32'hCAFEA5A5;
      frame(16'h01A5, 1, 1'b0);

      // Address wrap and truncation of the high address bits.
      wbuf[0] = 32'h11111111;
      wbuf[1] = 32'h22222222;
      frame(16'h3FFF, 2, 1'b0);
      check("wrap_last_addr", mem_addr, 14'h0000);
      wbuf[0] = 32'h0BADF00D;
      frame(16'hC005, 1, 1'b0);
      check("trunc_addr", mem_addr, 14'h0005);

      // Zero-length frame: done without any write.
      w0 = wr_cnt;
      frame(16'h0010, 0, 1'b0);
      check("len0_no_write", wr_cnt, w0);

      // Reset after two data bytes: no write, outputs back to reset values.
      w0 = wr_cnt;
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'h02);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'hAA);
      send_byte(8'hBB);
      rstn = 1'b0;
      rx_valid = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_rx_ready", rx_ready, 1);
      check("midrst_mem_addr", mem_addr, 0);
      check("midrst_mem_din", mem_din, 0);
      check("midrst_mem_we", mem_we, 0);
      @(negedge clk);
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      check("midrst_no_write", wr_cnt, w0);
      wbuf[0] = 32'h01020304;
      frame(16'h0200, 1, 1'b0);

`ifdef PROGMEM_LOADER_CHECKSUM_EN
      // Bad checksum sets err; the word already written stays; next sync clears err.
      wbuf[0] = 32'h55AA55AA;
      frame(16'h0100, 1, 1'b1);
      d0 = done_cnt;
      send_byte(8'hA5);
      check("sync_clears_err", err, 0);
      send_byte(8'h10);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h10);
      rx_valid = 1'b0;
      wait_done(d0, 1'b1);
      check("good_chk_err", err, 0);
`else
      d0 = done_cnt;
      check("err_tied_low", err, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
